// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the BCD down-counter
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit register with load and borrow chain
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  bcd_digit_t load_digit_i,
    input  logic       borrow_i,
    output bcd_digit_t digit_o,
    output logic       borrow_o
);

    bcd_digit_t digit_q, digit_d;

    assign digit_o  = digit_q;
    assign borrow_o = borrow_i && (digit_q == 4'd0);

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_digit_i;
        end else if (borrow_i) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown timer; BCD_AUTO_RELOAD_EN enables periodic reload
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              start,
    input  logic              pause,
    input  logic              tick,
    output logic [4*NDIG-1:0] count,
    output logic              busy,
    output logic              zero,
    output logic              done,
    output logic              load_err
);

    localparam int CW = 4 * NDIG;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          load_err_q, load_err_d;
    logic          load_ok;
    logic          digit_load;
    logic          dec_en;
    logic          count_zero;
    logic          count_one;
    logic [CW-1:0] load_src;
    logic [NDIG:0] borrow;
    logic          borrow_unused;

`ifdef BCD_AUTO_RELOAD_EN
    logic [CW-1:0] reload_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load && load_ok) begin
            reload_q <= load_val;
        end
    end
`endif

    assign count_zero = (count == '0);
    assign count_one  = (count == CW'(1));

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        digit_load = 1'b0;
        dec_en     = 1'b0;
        load_src   = load_val;
        if (load) begin
            if (load_ok) begin
                digit_load = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (start) begin
                        if (count_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
`ifdef BCD_AUTO_RELOAD_EN
                    // Count sits at zero for exactly one RUN cycle (the done cycle) before reloading.
                    if (count_zero) begin
                        digit_load = 1'b1;
                        load_src   = reload_q;
                    end else
`endif
                    if (pause) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        dec_en = 1'b1;
                        if (count_one) begin
                            done_d  = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
                            state_d = (reload_q == '0) ? ST_DONE : ST_RUN;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign borrow[0] = dec_en;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk          (clk),
            .reset_n      (reset_n),
            .load_i       (digit_load),
            .load_digit_i (load_src[4*g +: 4]),
            .borrow_i     (borrow[g]),
            .digit_o      (count[4*g +: 4]),
            .borrow_o     (borrow[g+1])
        );
    end

    // Decrement is never enabled at zero, so the top digit cannot borrow.
    assign borrow_unused = borrow[NDIG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign zero     = count_zero;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - scoreboard testbench for bcd_down_counter (NDIG=2)
module tb_bcd_down_counter;

`ifdef BCD_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HOLD = 2;
    localparam int S_DONE = 3;

    typedef struct packed {
        logic       ld;
        logic [7:0] v;
        logic       st;
        logic       ps;
        logic       tk;
    } stim_t;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] count;
    logic       busy;
    logic       zero;
    logic       done;
    logic       load_err;

    int n_pass;
    int n_total;

    int   m_val;
    int   m_reload;
    int   m_state;
    logic m_done;
    logic m_err;

    logic [11:0] exp_q[$];

    bcd_down_counter #(.NDIG(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .count    (count),
        .busy     (busy),
        .zero     (zero),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic ld, input logic [7:0] v,
                                 input logic st, input logic ps, input logic tk);
        stim_t s;
        s.ld = ld; s.v = v; s.st = st; s.ps = ps; s.tk = tk;
        return s;
    endfunction

    function automatic logic [11:0] obs();
        return {count, busy, zero, done, load_err};
    endfunction

    function automatic logic [11:0] model_vec();
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(m_val / 10);
        lo = 4'(m_val % 10);
        return {hi, lo, (m_state == S_RUN), (m_val == 0), m_done, m_err};
    endfunction

    task automatic model_reset();
        m_val = 0; m_reload = 0; m_state = S_IDLE; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        logic valid;
        valid  = (s.v[7:4] <= 4'd9) && (s.v[3:0] <= 4'd9);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (s.ld) begin
            if (valid) begin
                m_val    = int'(s.v[7:4]) * 10 + int'(s.v[3:0]);
                m_reload = m_val;
                m_state  = S_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if ((m_state == S_IDLE || m_state == S_HOLD) && s.st) begin
            if (m_val == 0) begin
                m_state = S_DONE;
                m_done  = 1'b1;
            end else begin
                m_state = S_RUN;
            end
        end else if (m_state == S_RUN) begin
            if (AUTO && m_val == 0) begin
                m_val = m_reload;
            end else if (s.ps) begin
                m_state = S_HOLD;
            end else if (s.tk) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1'b1;
                    if (!(AUTO && m_reload != 0)) m_state = S_DONE;
                end
            end
        end
    endtask

    task automatic cycle(input stim_t s);
        load = s.ld; load_val = s.v; start = s.st; pause = s.ps; tick = s.tk;
        model_step(s);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        reset_n = 1'b0;
        load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0; tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        e = 12'b0000_0000_0_1_0_0;
        n_total++;
        if (obs() === e) n_pass++;
        else $display("FAIL reset_state: got %h want %h (count,busy,zero,done,load_err)", obs(), e);
        reset_n = 1'b1;
    endtask

    task automatic test_countdown();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 25; i++) s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL countdown step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
            if (!AUTO && i == 26) begin
                n_total++;
                if (count === 8'h00 && done === 1'b1 && busy === 1'b0) n_pass++;
                else $display("FAIL countdown_at_zero: got count=%h done=%b busy=%b want 00 1 0", count, done, busy);
            end
        end
    endtask

    task automatic test_borrow_and_bad_load();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h10, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b1, 8'h3A, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL borrow_badload step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
            if (i == 2) begin
                n_total++;
                if (count === 8'h09) n_pass++;
                else $display("FAIL borrow_10_to_09: got %h want 09", count);
            end
            if (i == 3) begin
                n_total++;
                if (count === 8'h09 && load_err === 1'b1 && busy === 1'b1) n_pass++;
                else $display("FAIL bad_load_3A: got count=%h err=%b busy=%b want 09 1 1", count, load_err, busy);
            end
        end
    endtask

    task automatic test_pause();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL pause step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
        end
        n_total++;
        if (count === 8'h04 && busy === 1'b1) n_pass++;
        else $display("FAIL pause_resume: got count=%h busy=%b want 04 1", count, busy);
    endtask

    task automatic test_zero_start();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL zero_start step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
            if (i == 1) begin
                n_total++;
                if (done === 1'b1 && busy === 1'b0 && count === 8'h00) n_pass++;
                else $display("FAIL zero_start_done: got done=%b busy=%b count=%h want 1 0 00", done, busy, count);
            end
        end
    endtask

    task automatic test_reload();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL reload step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
            if (AUTO && i == 5) begin
                n_total++;
                if (count === 8'h03 && busy === 1'b1 && done === 1'b0) n_pass++;
                else $display("FAIL reload_value: got count=%h busy=%b done=%b want 03 1 0", count, busy, done);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t s[$];
        logic [11:0] e;
        s.push_back(mk(1'b1, 8'h50, 1'b0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        foreach (s[i]) begin
            cycle(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL async_reset_pre step %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        e = 12'b0000_0000_0_1_0_0;
        n_total++;
        if (obs() === e) n_pass++;
        else $display("FAIL async_reset_immediate: got %h want %h", obs(), e);
        @(posedge clk);
        #1;
        n_total++;
        if (obs() === e) n_pass++;
        else $display("FAIL async_reset_held: got %h want %h", obs(), e);
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [11:0] e;
        for (int i = 0; i < 300; i++) begin
            s.ld = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) s.v = 8'($urandom);
            else s.v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            s.st = ($urandom_range(0, 4) == 0);
            s.ps = ($urandom_range(0, 9) == 0);
            s.tk = ($urandom_range(0, 1) == 0);
            cycle(s);
            e = exp_q.pop_front();
            n_total++;
            if (obs() === e) n_pass++;
            else $display("FAIL back_to_back cycle %0d: got %h want %h (count,busy,zero,done,load_err)", i, obs(), e);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_countdown();
        test_borrow_and_bad_load();
        test_pause();
        test_zero_start();
        test_reload();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
